// File: rtl/operand_sel_pipe.sv
// N-way operand select feeding a DEPTH-stage register chain with stall/flush and
// out-of-range select detection. Define OPERAND_SEL_ERRCNT_EN to add err_count.
module operand_sel_pipe #(
  parameter int              WIDTH       = 32,
  parameter int              N_IN        = 4,
  parameter int              SEL_W       = 2,
  parameter int              DEPTH       = 1,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_valid,
  input  logic                  stall,
  input  logic                  flush,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  output logic                  out_sel_err
`ifdef OPERAND_SEL_ERRCNT_EN
  ,
  output logic [7:0]            err_count
`endif
);

  // Flow control: an item is accepted on any edge with in_valid=1, stall=0 and
  // flush=0; while stall=1 nothing moves and the producer must hold its item.
  logic [WIDTH-1:0] sel_data;
  logic             sel_err;

  always_comb begin
    sel_data = DEFAULT_VAL;
    sel_err  = 1'b1;
    for (int k = 0; k < N_IN; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_data = in_bus[k*WIDTH +: WIDTH];
        sel_err  = 1'b0;
      end
    end
  end

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] err_q;

  // Reset and flush have the same effect on the stages; both beat stall.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
      valid_q <= '0;
      err_q   <= '0;
    end else if (!stall) begin
      data_q[0]  <= sel_data;
      valid_q[0] <= in_valid;
      err_q[0]   <= in_valid & sel_err;
      for (int i = 1; i < DEPTH; i++) begin
        data_q[i]  <= data_q[i-1];
        valid_q[i] <= valid_q[i-1];
        err_q[i]   <= err_q[i-1];
      end
    end
  end

  assign out_data    = data_q[DEPTH-1];
  assign out_valid   = valid_q[DEPTH-1];
  assign out_sel_err = err_q[DEPTH-1];

`ifdef OPERAND_SEL_ERRCNT_EN
  // Saturating count of erroneous items leaving the pipe; flush leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (out_valid && out_sel_err && !stall && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_operand_sel_pipe.sv
// Scoreboard bench for operand_sel_pipe: each accepted item is queued with the
// advance count at which it must reach the output; a negedge monitor pops and compares.
module tb_operand_sel_pipe;

  localparam int               WIDTH       = 32;
  localparam int               N_IN        = 3;
  localparam int               SEL_W       = 2;
  localparam int               DEPTH       = 3;
  localparam logic [WIDTH-1:0] DEFAULT_VAL = 32'hA5A5_0F0F;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  stall;
  logic                  flush;
  logic [SEL_W-1:0]      in_sel;
  logic [N_IN*WIDTH-1:0] in_bus;
  logic [WIDTH-1:0]      in_arr [N_IN];
  logic [WIDTH-1:0]      out_data;
  logic                  out_valid;
  logic                  out_sel_err;
`ifdef OPERAND_SEL_ERRCNT_EN
  logic [7:0]            err_count;
  int                    exp_cnt = 0;
`endif

  int checks   = 0;
  int failures = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always_comb begin
    in_bus = '0;
    for (int k = 0; k < N_IN; k++) begin
      in_bus[k*WIDTH +: WIDTH] = in_arr[k];
    end
  end

  operand_sel_pipe #(
    .WIDTH(WIDTH), .N_IN(N_IN), .SEL_W(SEL_W), .DEPTH(DEPTH), .DEFAULT_VAL(DEFAULT_VAL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_bus(in_bus),
    .in_sel(in_sel),
    .in_valid(in_valid),
    .stall(stall),
    .flush(flush),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_sel_err(out_sel_err)
`ifdef OPERAND_SEL_ERRCNT_EN
    ,
    .err_count(err_count)
`endif
  );

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {K_NONE, K_CLR, K_HOLD, K_ADV} kind_t;
  kind_t          kind = K_NONE;
  int             adv_cnt = 0;
  logic [WIDTH:0] exp_q [$];   // {err, data}
  int             due_q [$];   // advance count at which the item is at the output
  logic           mdl_out_err = 1'b0;

  always @(posedge clk) begin
    int idx;
    logic [WIDTH-1:0] d;
    logic e;
`ifdef OPERAND_SEL_ERRCNT_EN
    if (rst) exp_cnt = 0;
    else if (mdl_out_err && !stall && exp_cnt < 255) exp_cnt++;
`endif
    if (rst || flush) begin
      exp_q.delete();
      due_q.delete();
      kind = K_CLR;
      mdl_out_err = 1'b0;
    end else if (stall) begin
      kind = K_HOLD;
    end else begin
      adv_cnt++;
      kind = K_ADV;
      if (in_valid) begin
        idx = int'(in_sel);
        if (idx < N_IN) begin
          d = in_arr[idx];
          e = 1'b0;
        end else begin
          d = DEFAULT_VAL;
          e = 1'b1;
        end
        exp_q.push_back({e, d});
        due_q.push_back(adv_cnt + DEPTH - 1);
      end
      mdl_out_err = (due_q.size() > 0) && (due_q[0] == adv_cnt) && exp_q[0][WIDTH];
    end
  end

  // ---------------- monitor ----------------
  logic             exp_v = 1'b0;
  logic             exp_e = 1'b0;
  logic [WIDTH-1:0] exp_d = '0;
  logic             exp_d_known = 1'b0;

  always @(negedge clk) begin
    logic [WIDTH:0] item;
    case (kind)
      K_CLR: begin
        check("clr_valid", WIDTH'(out_valid), '0);
        check("clr_err", WIDTH'(out_sel_err), '0);
        check("clr_data", out_data, '0);
        exp_v = 1'b0; exp_e = 1'b0; exp_d = '0; exp_d_known = 1'b1;
      end
      K_HOLD: begin
        check("hold_valid", WIDTH'(out_valid), WIDTH'(exp_v));
        check("hold_err", WIDTH'(out_sel_err), WIDTH'(exp_e));
        if (exp_d_known) check("hold_data", out_data, exp_d);
      end
      K_ADV: begin
        if (due_q.size() > 0 && due_q[0] == adv_cnt) begin
          item = exp_q.pop_front();
          void'(due_q.pop_front());
          check("item_valid", WIDTH'(out_valid), WIDTH'(1));
          check("item_data", out_data, item[WIDTH-1:0]);
          check("item_err", WIDTH'(out_sel_err), WIDTH'(item[WIDTH]));
          exp_v = 1'b1; exp_e = item[WIDTH]; exp_d = item[WIDTH-1:0]; exp_d_known = 1'b1;
        end else begin
          check("idle_valid", WIDTH'(out_valid), '0);
          check("idle_err", WIDTH'(out_sel_err), '0);
          exp_v = 1'b0; exp_e = 1'b0; exp_d_known = 1'b0;
        end
      end
      default: ;
    endcase
`ifdef OPERAND_SEL_ERRCNT_EN
    if (kind != K_NONE) check("err_count", WIDTH'(err_count), WIDTH'(exp_cnt));
`endif
  end

  // ---------------- driver ----------------
  task automatic cyc(input logic v, input logic [SEL_W-1:0] s, input logic st,
                     input logic fl, input logic rs);
    @(negedge clk);
    in_valid = v;
    in_sel   = s;
    stall    = st;
    flush    = fl;
    rst      = rs;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = '0; stall = 1'b0; flush = 1'b0;
    for (int k = 0; k < N_IN; k++) in_arr[k] = '0;
    repeat (3) cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(1);

    // basic select including one out-of-range index
    in_arr[0] = 32'h1111_1111; in_arr[1] = 32'h2222_2222; in_arr[2] = 32'hFFFF_FFFF;
    for (int s = 0; s < 4; s++) cyc(1'b1, SEL_W'(s), 1'b0, 1'b0, 1'b0);
    idle(DEPTH + 1);
    // out-of-range while not valid
    cyc(1'b0, 2'd3, 1'b0, 1'b0, 1'b0);
    idle(DEPTH + 1);

    // A, B, C then a two-cycle stall (inputs during stall are not captured)
    for (int s = 0; s < 3; s++) cyc(1'b1, SEL_W'(s), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    idle(DEPTH + 2);

    // flush together with stall while items are in flight
    cyc(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 2'd2, 1'b1, 1'b1, 1'b0);
    idle(DEPTH + 1);

    // reset with three items in flight
    for (int s = 0; s < 3; s++) cyc(1'b1, SEL_W'(s), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
    idle(DEPTH + 1);

    // randomized traffic
    repeat (600) begin
      cyc(1'($urandom_range(0, 1)), SEL_W'($urandom_range(0, 3)),
          $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0);
      for (int k = 0; k < N_IN; k++) in_arr[k] = $urandom;
    end
    idle(DEPTH + 1);

`ifdef OPERAND_SEL_ERRCNT_EN
    repeat (300) cyc(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 2'd3, 1'b0, 1'b1, 1'b0);
    idle(DEPTH + 1);
    checks++;
    if (err_count !== 8'd255) begin
      failures++;
      $display("FAIL err_sat: got %0d expected 255", err_count);
    end
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(2);
`endif

    idle(DEPTH + 2);
    check("drain_empty", WIDTH'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_sel_pipe.md
Name: operand_sel_pipe

Overview:
- Parametrised N-way operand select with a configurable pipeline register chain and pipeline-control inputs.
- Successor to the fixed 4:1 combinational 32-bit select used on the ALU operand/forwarding paths of the 5-stage core.
- Adds:
  - generic input count and width;
  - 1..4 registered stages;
  - valid tracking;
  - stall (hold) and flush;
  - out-of-range select detection.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- N_IN, 4, number of selectable inputs (2..16).
- SEL_W, 2, select width; must satisfy 2^SEL_W >= N_IN.
- DEPTH, 1, number of register stages from input to output (1..4).
- DEFAULT_VAL, 0, value driven into the pipe when the select is out of range.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_bus  in  N_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
- in_sel  in  SEL_W  select index.
- in_valid  in  1  current select/data are meaningful.
- stall  in  1  hold every stage's contents.
- flush  in  1  invalidate every stage.
- out_data  out  WIDTH  selected data after DEPTH cycles, signed two's-complement, passed unmodified.
- out_valid  out  1  out_data is meaningful.
- out_sel_err  out  1  the item at the output had in_sel >= N_IN.

Behaviour:
- Select stage (combinational, ahead of stage 1):
  - sel < N_IN: data = input[sel], err = 0.
  - sel >= N_IN: data = DEFAULT_VAL, err = 1.
  - Never drives X.
- Each stage i holds {data, valid, err}. Stage 1 loads from the select stage; stage i loads from stage i-1. The output ports are the last stage, so latency is exactly DEPTH cycles with no stall.
- Reset (rst=1 at a clock edge):
  - All stage data = 0, valid = 0, err = 0.
  - Hence out_data = 0, out_valid = 0, out_sel_err = 0.
  - Overrides stall and flush; mid-operation reset discards all in-flight items.
- Priority per edge: rst > flush > stall > normal advance.
- Flush:
  - All stage valid and err bits are cleared.
  - Data registers are cleared to 0.
  - The item presented on the same cycle is dropped.
- Stall (without flush):
  - All stages keep their contents.
  - The input on that cycle is not captured; the upstream stage must hold it.
- Normal advance:
  - Every stage shifts.
  - Stage 1 captures valid = in_valid and err = in_valid & out-of-range.
  - When in_valid = 0, stage 1 data is still captured (don't-care to consumers) and its err is 0.
- out_sel_err is qualified by out_valid; it is never 1 while out_valid = 0.
- No combinational path from any input to any output.
- Signedness: data is not extended or truncated; WIDTH in = WIDTH out.

Optional Feature:
- Macro: OPERAND_SEL_ERRCNT_EN.
- When defined:
  - Adds output err_count [7:0].
  - Increments by 1 on each edge where out_valid = 1, out_sel_err = 1 and stall = 0.
  - Saturates at 255.
  - Cleared by rst only; flush does not clear it.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Basic select, DEPTH=1, N_IN=4, WIDTH=32:
  - Stimulus: inputs 0x11111111, 0x22222222, 0x33333333, 0xFFFFFFFF; sel 0,1,2,3 with in_valid=1 on consecutive cycles.
  - Required: out_data equals each input one cycle later; out_valid = 1; out_sel_err = 0.
- Out-of-range, N_IN=3, SEL_W=2:
  - Stimulus: sel = 3 with in_valid = 1.
  - Required: after DEPTH cycles out_data = 0 (DEFAULT_VAL), out_sel_err = 1, out_valid = 1.
  - Stimulus: same with in_valid = 0.
  - Required: out_valid = 0, out_sel_err = 0.
- Stall, DEPTH=3:
  - Stimulus: feed A, B, C on consecutive cycles, then assert stall for 2 cycles.
  - Required: output sequence A, held A, held A, then B, C; no item lost or duplicated beyond the hold.
- Flush vs stall, DEPTH=2:
  - Stimulus: two valid items in flight; assert flush and stall together.
  - Required: next cycle out_valid = 0, out_data = 0; the item presented during the flush cycle never appears.
- Reset mid-stream, DEPTH=4:
  - Stimulus: rst = 1 for one cycle while 3 items are in flight.
  - Required: out_valid = 0 for the following 4 cycles unless new items are fed; all outputs = 0 immediately after the reset edge.
- Error counter, with OPERAND_SEL_ERRCNT_EN defined:
  - Stimulus: 300 consecutive out-of-range selects.
  - Required: err_count reaches 255 and stays there.
  - Stimulus: flush.
  - Required: err_count remains 255.
  - Stimulus: rst.
  - Required: err_count = 0.
